data_ram_arbiter: RTL and testbench

Shares the single-port data RAM between the processor data port and a host/loader port. Per-cycle arbitration with CPU priority, a starvation guard for the host, and a bounded host burst lock. Sits between `processor` (data interface), the host loader and the data `ram` instance. The RAM has one-cycle registered read latency.

---
 rtl/data_ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the CPU data port
// and the host/loader port. CPU has priority each cycle, a host lock holds the
// RAM for a bounded burst, and read data returns one cycle after acceptance.
// Optional feature macro: ARB_STARVE_GUARD_EN (host starvation guard).
module data_ram_arbiter #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_rvalid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  input  logic                 host_lock,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout
);

  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               host_rvalid_q, host_rvalid_d;
  logic               guard_trip;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign guard_trip = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  // Count consecutive denied host cycles, saturating; any grant or idle clears
  always_comb begin
    wait_cnt_d = '0;
    if (host_req && !host_gnt) begin
      if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign guard_trip = 1'b0;
`endif

  // Same-cycle grant: lock owner first, then tripped guard, then CPU, then host
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (reset) begin
      if (state_q == ST_LOCKED) begin
        host_gnt = host_req;
      end else if (host_req && guard_trip) begin
        host_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else begin
        host_gnt = host_req;
      end
    end
  end

  // RAM drive from the granted port, all zero when idle
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (cpu_gnt) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end else if (host_gnt) begin
      ram_we   = host_we;
      ram_addr = host_addr;
      ram_din  = host_wdata;
    end
  end

  // Lock FSM next state, burst length and read-owner tracking
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    cpu_rvalid_d  = cpu_req & cpu_gnt & ~cpu_we;
    host_rvalid_d = host_req & host_gnt & ~host_we;
    case (state_q)
      ST_OPEN: begin
        if (host_req && host_gnt && host_lock) begin
          state_d     = ST_LOCKED;
          burst_cnt_d = BURST_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!host_lock || (burst_cnt_q == BURST_W'(BURST_MAX))) begin
          state_d     = ST_OPEN;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end
      default: begin
        state_d     = ST_OPEN;
        burst_cnt_d = '0;
      end
    endcase
  end

  // State and read-owner registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_OPEN;
      burst_cnt_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // A read accepted just before reset asserts must not be reported
  assign cpu_rvalid  = cpu_rvalid_q & reset;
  assign host_rvalid = host_rvalid_q & reset;
  assign cpu_rdata   = ram_dout;
  assign host_rdata  = ram_dout;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed scenarios plus random traffic,
// every cycle checked against a behavioural arbitration model.
module tb_data_ram_arbiter;

  localparam int unsigned AW        = 18;
  localparam int unsigned DW        = 18;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned BURST_MAX = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  data_ram_arbiter #(
    .ADDR_SIZE(AW), .WORD_SIZE(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_lock(host_lock),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Small RAM with registered read; low four address bits select the word
  logic [DW-1:0] ram_mem [0:15];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr[3:0]] <= ram_din;
    ram_dout <= ram_mem[ram_addr[3:0]];
  end

  // Reference model state
  bit            m_locked;
  int            m_burst, m_wait;
  bit            m_crv, m_hrv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:15];

  // Observations from the last cycle, for scenario-level checks
  bit            o_cg, o_hg, o_we, o_crv, o_hrv;
  logic [DW-1:0] o_crdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check against model, then advance model at the edge
  task automatic run_cycle(input bit rst, input bit cr, input bit cw,
                           input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                           input bit hr, input bit hw,
                           input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                           input bit hl);
    bit            e_cg, e_hg, e_we, tripped;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    @(negedge clock);
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    #1;
    tripped = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    tripped = (m_wait >= int'(MAX_WAIT));
`endif
    e_cg = 1'b0;
    e_hg = 1'b0;
    if (rst) begin
      if (m_locked) e_hg = hr;
      else if (hr && (tripped || !cr)) e_hg = 1'b1;
      else e_cg = cr;
    end
    e_we   = (e_cg && cw) || (e_hg && hw);
    e_addr = e_cg ? ca : (e_hg ? ha : '0);
    e_din  = e_cg ? cd : (e_hg ? hd : '0);
    check_val("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check_val("host_gnt", 32'(host_gnt), 32'(e_hg));
    check_val("ram_we", 32'(ram_we), 32'(e_we));
    check_val("ram_addr", 32'(ram_addr), 32'(e_addr));
    check_val("ram_din", 32'(ram_din), 32'(e_din));
    check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv && rst));
    check_val("host_rvalid", 32'(host_rvalid), 32'(m_hrv && rst));
    if (m_crv && rst) check_val("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
    if (m_hrv && rst) check_val("host_rdata", 32'(host_rdata), 32'(m_rdata));
    o_cg = cpu_gnt; o_hg = host_gnt; o_we = ram_we;
    o_crv = cpu_rvalid; o_hrv = host_rvalid; o_crdata = cpu_rdata;
    @(posedge clock);
    if (!rst) begin
      m_locked = 1'b0; m_burst = 0; m_wait = 0; m_crv = 1'b0; m_hrv = 1'b0;
    end else begin
      m_crv = e_cg && !cw;
      m_hrv = e_hg && !hw;
      if (e_cg || e_hg) begin
        if (e_we) ref_mem[e_addr[3:0]] = e_din;
        else m_rdata = ref_mem[e_addr[3:0]];
      end
      if (hr && !e_hg) m_wait = (m_wait < int'(MAX_WAIT)) ? m_wait + 1 : m_wait;
      else m_wait = 0;
      if (m_locked) begin
        if (!hl || m_burst == int'(BURST_MAX)) begin
          m_locked = 1'b0; m_burst = 0;
        end else begin
          m_burst++;
        end
      end else if (e_hg && hl) begin
        m_locked = 1'b1; m_burst = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    int            hg_cnt, streak;
    bit            saw_cpu, cr, cw, hr, hw, hl, rst, pc, ph;
    logic [AW-1:0] ca, ha;
    logic [DW-1:0] cd, hd;
    m_locked = 0; m_burst = 0; m_wait = 0; m_crv = 0; m_hrv = 0; m_rdata = '0;
    reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;

    // Reset hold with both ports requesting
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 1, AW'(1), DW'(7), 1, 1, AW'(2), DW'(9), 1);
      check_val("rst_hold_gnt", 32'({o_cg, o_hg, o_we}), 32'(0));
      check_val("rst_hold_rvalid", 32'({o_crv, o_hrv}), 32'(0));
    end
    run_cycle(1, 1, 1, AW'(1), DW'(7), 1, 1, AW'(2), DW'(9), 0);
    check_val("rst_release_cpu_gnt", 32'(o_cg), 32'(1));

    // Preload every RAM word so all reads are defined
    for (int i = 0; i < 16; i++)
      run_cycle(1, 1, 1, AW'(i), DW'($urandom), 0, 0, '0, '0, 0);

    // CPU write then read of address 5
    run_cycle(1, 1, 1, AW'(5), DW'(18'h3FFFF), 0, 0, '0, '0, 0);
    check_val("wr_cycle_we", 32'(o_we), 32'(1));
    run_cycle(1, 1, 0, AW'(5), '0, 0, 0, '0, '0, 0);
    check_val("rd_cycle_we", 32'(o_we), 32'(0));
    run_cycle(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    check_val("wr_rd_rvalid", 32'(o_crv), 32'(1));
    check_val("wr_rd_data", 32'(o_crdata), 32'(18'h3FFFF));
    check_val("wr_rd_host_rvalid", 32'(o_hrv), 32'(0));

    // Both ports read continuously, no lock
    idle(1);
    hg_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1, 1, 0, AW'(i), '0, 1, 0, AW'(i + 3), '0, 0);
      if (o_hg) hg_cnt++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check_val("starve_host_grants", 32'(hg_cnt), 32'(4));
`else
    check_val("starve_host_grants", 32'(hg_cnt), 32'(0));
`endif

    // Forced burst exit with CPU requesting throughout the lock
    idle(1);
    run_cycle(1, 0, 0, '0, '0, 1, 0, AW'(3), '0, 1);
    check_val("burst_entry_gnt", 32'(o_hg), 32'(1));
    streak = 0;
    saw_cpu = 0;
    for (int i = 0; i < 30 && !saw_cpu; i++) begin
      run_cycle(1, 1, 0, AW'(4), '0, 1, 0, AW'(i), '0, 1);
      if (o_cg) saw_cpu = 1;
      else if (o_hg) streak++;
    end
    check_val("burst_locked_cycles", 32'(streak), 32'(BURST_MAX));
    check_val("burst_cpu_after", 32'(saw_cpu), 32'(1));

    // Voluntary lock release after the third host transfer
    idle(1);
    run_cycle(1, 0, 0, '0, '0, 1, 1, AW'(8), DW'(11), 1);
    run_cycle(1, 1, 0, AW'(1), '0, 1, 1, AW'(9), DW'(12), 1);
    check_val("vol_xfer2", 32'(o_hg), 32'(1));
    run_cycle(1, 1, 0, AW'(1), '0, 1, 1, AW'(10), DW'(13), 0);
    check_val("vol_xfer3", 32'(o_hg), 32'(1));
    run_cycle(1, 1, 0, AW'(1), '0, 1, 1, AW'(11), DW'(14), 0);
    check_val("vol_cpu_next", 32'(o_cg), 32'(1));

    // Reset right after an accepted host read that also locked
    idle(1);
    run_cycle(1, 0, 0, '0, '0, 1, 0, AW'(6), '0, 1);
    run_cycle(0, 1, 0, AW'(2), '0, 1, 0, AW'(6), '0, 1);
    check_val("rst_after_rd_rvalid", 32'(o_hrv), 32'(0));
    run_cycle(1, 1, 0, AW'(2), '0, 1, 0, AW'(6), '0, 1);
    check_val("rst_after_rd_rvalid2", 32'(o_hrv), 32'(0));
    check_val("rst_after_rd_open", 32'(o_cg), 32'(1));

    // Random traffic, fields held while a request waits
    pc = 0; ph = 0;
    cr = 0; cw = 0; ca = '0; cd = '0; hr = 0; hw = 0; ha = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      if (!(pc && cr)) begin
        cr = ($urandom_range(0, 2) != 0);
        cw = $urandom_range(0, 1) != 0; ca = AW'($urandom); cd = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        cr = 0;
      end
      if (!(ph && hr)) begin
        hr = ($urandom_range(0, 2) != 0);
        hw = $urandom_range(0, 1) != 0; ha = AW'($urandom); hd = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        hr = 0;
      end
      hl = ($urandom_range(0, 3) != 0);
      run_cycle(rst, cr, cw, ca, cd, hr, hw, ha, hd, hl);
      pc = cr && !o_cg && rst;
      ph = hr && !o_hg && rst;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
